// File: rtl/sbase_pgcb_n_if.sv
// sbase_pgcb_n_if: sequencer/pulse-generator handshake bundle for sbase_pgcb_n
interface sbase_pgcb_n_if #(parameter int CNT_W = 8);
  logic             trg_one;
  logic             rdy_in;
  logic             fb;
  logic             mode;
  logic [CNT_W-1:0] target;
  logic             abort;
  logic [CNT_W-1:0] q;
  logic             pout_one;
  logic             rdy;
  logic             done;
  logic [1:0]       stat;
  modport master (
    output trg_one, rdy_in, fb, mode, target, abort,
    input  q, pout_one, rdy, done, stat
  );
  modport slave (
    input  trg_one, rdy_in, fb, mode, target, abort,
    output q, pout_one, rdy, done, stat
  );
endinterface

// File: rtl/sbase_pgcb_n.sv
// sbase_pgcb_n: counted/free-run step pulse controller; watchdog built only with SBASE_PGCB_TIMEOUT_EN
module sbase_pgcb_n #(
  parameter int CNT_W     = 8,
  parameter int TO_CYCLES = 1024
) (
  input logic          CLK,
  input logic          R,
  sbase_pgcb_n_if.slave b
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_d;
  logic             s0, s1, pos, go, zero_go, to_hit, stop;
  logic             md, md_d, pout_d, done_d;
  logic [CNT_W-1:0] tgt, tgt_d, q_d;
  logic [1:0]       stat_d;
  if (CNT_W < 2 || TO_CYCLES < 1) begin : g_bad_param
    $error("sbase_pgcb_n: CNT_W must be >= 2 and TO_CYCLES >= 1");
  end
  assign pos     = s0 & ~s1;
  assign go      = state == IDLE && b.trg_one && b.rdy_in && !b.abort;
  assign zero_go = b.mode && b.target == '0;
  assign stop    = b.abort || to_hit || (pos && (b.fb || (md && b.q == tgt)));
  assign b.rdy   = state == IDLE;
`ifdef SBASE_PGCB_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYCLES + 1);
  logic [WD_W-1:0] wd;
  // wd counts RUN edges since the last pulse; it hits the limit on the TO_CYCLES-th edge
  assign to_hit = state == RUN && wd == WD_W'(TO_CYCLES - 1);
  always_ff @(posedge CLK)
    if (R || state != RUN || pout_d) wd <= '0;
    else wd <= wd + 1'b1;
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge CLK)
    if (R) begin
      state      <= IDLE;
      s0         <= 1'b0;
      s1         <= 1'b0;
      md         <= 1'b0;
      tgt        <= '0;
      b.q        <= '0;
      b.pout_one <= 1'b0;
      b.done     <= 1'b0;
      b.stat     <= 2'b00;
    end else begin
      state      <= state_d;
      s0         <= b.rdy_in;
      s1         <= s0;
      md         <= md_d;
      tgt        <= tgt_d;
      b.q        <= q_d;
      b.pout_one <= pout_d;
      b.done     <= done_d;
      b.stat     <= stat_d;
    end
  always_comb
    state_d = state == IDLE ? (go && !zero_go ? RUN : IDLE) : (stop ? IDLE : RUN);
  always_comb begin
    q_d    = b.q;
    pout_d = 1'b0;
    done_d = 1'b0;
    stat_d = b.stat;
    tgt_d  = tgt;
    md_d   = md;
    if (state == IDLE) begin
      if (go) begin
        q_d    = zero_go ? '0 : CNT_W'(1);
        pout_d = !zero_go;
        done_d = zero_go;
        stat_d = 2'b00;
        tgt_d  = b.target;
        md_d   = b.mode;
      end
    end else if (b.abort) begin
      done_d = 1'b1;
      stat_d = 2'b10;
    end else if (to_hit) begin
      done_d = 1'b1;
      stat_d = 2'b11;
    end else if (pos) begin
      done_d = b.fb || (md && b.q == tgt);
      stat_d = b.fb ? 2'b01 : 2'b00;
      pout_d = !done_d;
      q_d    = done_d ? b.q : b.q + 1'b1;
    end
  end
endmodule

// File: tb/tb_sbase_pgcb_n.sv
// tb_sbase_pgcb_n: directed and random checks of sbase_pgcb_n against a behavioural model
module tb_sbase_pgcb_n;
  localparam int W  = 2;
  localparam int TO = 16;
`ifdef SBASE_PGCB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  logic CLK = 1'b0;
  logic R   = 1'b1;
  always #5 CLK = ~CLK;
  sbase_pgcb_n_if #(.CNT_W(W)) bus ();
  sbase_pgcb_n #(.CNT_W(W), .TO_CYCLES(TO)) dut (.CLK(CLK), .R(R), .b(bus));
  int n_cmp = 0, n_bad = 0, pulses = 0, dones = 0, p0, d0;
  bit chk_en = 1'b0;
  bit m_run, m_s0, m_s1, m_md, m_pout, m_done;
  int m_q, m_tgt, m_wait, m_stat;
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge CLK) begin : model
    bit pos;
    pos    = m_s0 && !m_s1;
    m_pout = 1'b0;
    m_done = 1'b0;
    if (R) begin
      m_run = 1'b0; m_s0 = 1'b0; m_s1 = 1'b0; m_q = 0; m_stat = 0;
    end else begin
      m_s1 = m_s0;
      m_s0 = bus.rdy_in;
      if (!m_run) begin
        if (bus.trg_one && bus.rdy_in && !bus.abort) begin
          if (bus.mode && int'(bus.target) == 0) begin
            m_done = 1'b1; m_stat = 0; m_q = 0;
          end else begin
            m_run = 1'b1; m_q = 1; m_pout = 1'b1; m_stat = 0;
            m_tgt = int'(bus.target); m_md = bus.mode; m_wait = 0;
          end
        end
      end else begin
        m_wait++;
        if (bus.abort) begin
          m_run = 1'b0; m_done = 1'b1; m_stat = 2;
        end else if (TO_ON && m_wait == TO) begin
          m_run = 1'b0; m_done = 1'b1; m_stat = 3;
        end else if (pos && bus.fb) begin
          m_run = 1'b0; m_done = 1'b1; m_stat = 1;
        end else if (pos && m_md && m_q == m_tgt) begin
          m_run = 1'b0; m_done = 1'b1; m_stat = 0;
        end else if (pos) begin
          m_pout = 1'b1; m_q = (m_q + 1) % (1 << W); m_wait = 0;
        end
      end
    end
  end
  always @(negedge CLK) begin
    if (bus.pout_one === 1'b1) pulses++;
    if (bus.done === 1'b1) dones++;
    if (chk_en) begin
      chk("model_q",    int'(bus.q),        m_q);
      chk("model_pout", int'(bus.pout_one), int'(m_pout));
      chk("model_rdy",  int'(bus.rdy),      int'(!m_run));
      chk("model_done", int'(bus.done),     int'(m_done));
      chk("model_stat", int'(bus.stat),     m_stat);
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic trig(bit md, int tg);
    bus.mode = md; bus.target = W'(tg); bus.trg_one = 1'b1;
    cyc(1);
    bus.trg_one = 1'b0;
  endtask
  task automatic rise(bit f, bit a);
    bus.rdy_in = 1'b0;
    cyc(2);
    bus.rdy_in = 1'b1; bus.fb = f;
    cyc(1);
    bus.abort = a;
    cyc(1);
    bus.abort = 1'b0;
    cyc(2);
    bus.fb = 1'b0;
  endtask
  task automatic snap();
    p0 = pulses; d0 = dones;
  endtask
  initial begin
    bus.trg_one = 1'b0; bus.rdy_in = 1'b0; bus.fb = 1'b0; bus.mode = 1'b0;
    bus.target = '0; bus.abort = 1'b0;
    R = 1'b1;
    cyc(2);
    chk("t1_q", int'(bus.q), 0);
    chk("t1_rdy", int'(bus.rdy), 1);
    chk("t1_pout", int'(bus.pout_one), 0);
    chk("t1_done", int'(bus.done), 0);
    chk("t1_stat", int'(bus.stat), 0);
    R = 1'b0;
    chk_en = 1'b1;
    bus.rdy_in = 1'b1;
    cyc(3);
    snap();
    trig(1'b1, 3);
    repeat (3) rise(1'b0, 1'b0);
    cyc(2);
    chk("t2_pulses", pulses - p0, 3);
    chk("t2_dones", dones - d0, 1);
    chk("t2_q", int'(bus.q), 3);
    chk("t2_stat", int'(bus.stat), 0);
    chk("t2_rdy", int'(bus.rdy), 1);
    cyc(2);
    snap();
    trig(1'b0, 0);
    repeat (4) rise(1'b0, 1'b0);
    rise(1'b1, 1'b0);
    cyc(2);
    chk("t3_pulses", pulses - p0, 5);
    chk("t3_q", int'(bus.q), 1);
    chk("t3_stat", int'(bus.stat), 1);
    chk("t3_dones", dones - d0, 1);
    cyc(2);
    snap();
    trig(1'b0, 0);
    rise(1'b0, 1'b0);
    rise(1'b0, 1'b1);
    cyc(2);
    chk("t4_pulses", pulses - p0, 2);
    chk("t4_q", int'(bus.q), 2);
    chk("t4_stat", int'(bus.stat), 2);
    chk("t4_dones", dones - d0, 1);
    cyc(2);
    snap();
    trig(1'b1, 0);
    chk("t5_done", int'(bus.done), 1);
    chk("t5_rdy", int'(bus.rdy), 1);
    chk("t5_pout", int'(bus.pout_one), 0);
    chk("t5_q", int'(bus.q), 0);
    chk("t5_stat", int'(bus.stat), 0);
    bus.rdy_in = 1'b0;
    cyc(2);
    trig(1'b0, 0);
    cyc(1);
    chk("t5_ign_rdy", int'(bus.rdy), 1);
    chk("t5_ign_pulses", pulses - p0, 0);
    bus.rdy_in = 1'b1;
    cyc(3);
    trig(1'b0, 0);
    cyc(15);
    chk("t6_early_done", int'(bus.done), 0);
    chk("t6_early_rdy", int'(bus.rdy), 0);
    cyc(1);
    chk("t6_done", int'(bus.done), int'(TO_ON));
    chk("t6_stat", int'(bus.stat), TO_ON ? 3 : 0);
    cyc(14);
    chk("t6_hold_rdy", int'(bus.rdy), int'(TO_ON));
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    cyc(1);
    chk("t6_idle_rdy", int'(bus.rdy), 1);
    for (int i = 0; i < 4000; i++) begin
      R           = $urandom_range(0, 199) == 0;
      bus.trg_one = $urandom_range(0, 7) == 0;
      bus.mode    = 1'($urandom_range(0, 1));
      bus.target  = W'($urandom_range(0, 3));
      bus.abort   = $urandom_range(0, 59) == 0;
      bus.fb      = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 2) == 0) bus.rdy_in = ~bus.rdy_in;
      cyc(1);
    end
    R = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
